// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter: FSM states, frame field widths
// and parity mode encodings.
package uart_pkg;

  localparam int DATA_W  = 16;
  localparam int WIDTH_W = 4;
  localparam int PAR_W   = 2;

  // Parity field: bit 1 enables parity, bit 0 selects odd.
  localparam logic [PAR_W-1:0] PAR_NONE = 2'b00;
  localparam logic [PAR_W-1:0] PAR_EVEN = 2'b10;
  localparam logic [PAR_W-1:0] PAR_ODD  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [WIDTH_W-1:0] width;
    logic [PAR_W-1:0]   parity;
  } frame_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index at or after i_ptr,
// searching upward modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  always_comb begin
    int k;
    k       = 0;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int off = 0; off < N; off++) begin
      k = (int'(i_ptr) + off) % N;
      if (!o_any && i_valid[k]) begin
        o_any      = 1'b1;
        o_idx      = PW'(k);
        o_grant[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer between REQUESTERS
// producers, with inter-frame gap and a stall watchdog.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int REQUESTERS       = 4,
  parameter int MAX_FRAME_CYCLES = 40
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic [3:0]                    i_gap,
  input  logic [REQUESTERS-1:0]         i_req_valid,
  input  logic [DATA_W*REQUESTERS-1:0]  i_req_data,
  input  logic [WIDTH_W*REQUESTERS-1:0] i_req_width,
  input  logic [PAR_W*REQUESTERS-1:0]   i_req_parity,
  output logic [REQUESTERS-1:0]         o_req_ready,
  output logic [DATA_W-1:0]             o_tx_data,
  output logic [WIDTH_W-1:0]            o_tx_data_width,
  output logic [PAR_W-1:0]              o_tx_parity,
  output logic                          o_tx_load_ack,
  input  logic                          i_tx_load_req,
  output logic [2:0]                    o_grant_id,
  output logic                          o_busy,
  output logic                          o_drop,
  output logic                          o_timeout,
  output logic [15:0]                   o_sent_count
);

  localparam int PW  = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
  localparam int WDW = $clog2(MAX_FRAME_CYCLES + 1);

  arb_state_e            r_state, w_next;
  logic [PW-1:0]         r_ptr, w_idx, w_ptr_nxt;
  logic [REQUESTERS-1:0] w_grant;
  logic                  w_any, w_ser_idle, w_accept, w_done, w_to, w_zero;
  frame_t                r_frame, w_frame;
  logic                  r_load_ack;
  logic [2:0]            r_grant_id;
  logic [15:0]           r_sent;
  logic [WDW-1:0]        r_wd;
  logic [3:0]            r_gap;

  rr_pick #(.N(REQUESTERS), .PW(PW)) u_pick (
    .i_valid (i_req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_frame.data   = i_req_data[w_idx*DATA_W +: DATA_W];
  assign w_frame.width  = i_req_width[w_idx*WIDTH_W +: WIDTH_W];
  assign w_frame.parity = i_req_parity[w_idx*PAR_W +: PAR_W];
  assign w_zero         = (w_frame.width == '0);
  assign w_ser_idle     = (i_tx_load_req != r_load_ack);
  assign w_ptr_nxt      = (w_idx == PW'(REQUESTERS - 1)) ? '0 : w_idx + 1'b1;

  // A zero gap skips GAP entirely so back-to-back frames are w+p+4 apart.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_done   = 1'b0;
    w_to     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_enable && w_ser_idle && w_any) begin
          w_accept = 1'b1;
          if (!w_zero) w_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_ser_idle) begin
          w_done = 1'b1;
          w_next = (i_gap == 4'd0) ? ST_IDLE : ST_GAP;
        end else if (r_wd == WDW'(MAX_FRAME_CYCLES - 1)) begin
          w_to   = 1'b1;
          w_next = (i_gap == 4'd0) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (r_gap <= 4'd1) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state    <= ST_IDLE;
      r_ptr      <= '0;
      r_frame    <= '0;
      r_load_ack <= 1'b0;
      r_grant_id <= '0;
      r_sent     <= '0;
      r_wd       <= '0;
      r_gap      <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_grant_id <= 3'(w_idx);
        r_ptr      <= w_ptr_nxt;
        if (!w_zero) begin
          r_frame    <= w_frame;
          r_load_ack <= i_tx_load_req;
        end
      end
      if (r_state == ST_BUSY) r_wd <= r_wd + 1'b1;
      else                    r_wd <= '0;
      if (w_done) r_sent <= r_sent + 16'd1;
      // Forcing ack opposite to req returns a stalled serializer to idle.
      if (w_to) r_load_ack <= ~i_tx_load_req;
      if (w_done || w_to)        r_gap <= i_gap;
      else if (r_state == ST_GAP) r_gap <= r_gap - 4'd1;
    end
  end

  assign o_req_ready     = w_accept ? w_grant : '0;
  assign o_drop          = w_accept && w_zero;
  assign o_timeout       = w_to;
  assign o_busy          = (r_state == ST_BUSY);
  assign o_tx_data       = r_frame.data;
  assign o_tx_data_width = r_frame.width;
  assign o_tx_parity     = r_frame.parity;
  assign o_tx_load_ack   = r_load_ack;
  assign o_grant_id      = r_grant_id;
  assign o_sent_count    = r_sent;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model that
// records the serial line of each frame.
module tb_uart_tx_arbiter;

  localparam int R = 4;

  logic           clk = 1'b0, rst = 1'b1, en = 1'b1;
  logic [3:0]     gap = 4'd0;
  logic [R-1:0]   valid = '0;
  logic [16*R-1:0] data = '0;
  logic [4*R-1:0] width = '0;
  logic [2*R-1:0] par = '0;
  logic [R-1:0]   ready;
  logic [15:0]    tx_data, sent;
  logic [3:0]     tx_w;
  logic [1:0]     tx_p;
  logic           ack, req, busy, drop, tmo;
  logic [2:0]     gid;

  int vec_cnt = 0, err_cnt = 0;

  uart_tx_arbiter #(.REQUESTERS(R), .MAX_FRAME_CYCLES(40)) dut (
    .i_clock(clk), .i_reset(rst), .i_enable(en), .i_gap(gap),
    .i_req_valid(valid), .i_req_data(data), .i_req_width(width), .i_req_parity(par),
    .o_req_ready(ready), .o_tx_data(tx_data), .o_tx_data_width(tx_w), .o_tx_parity(tx_p),
    .o_tx_load_ack(ack), .i_tx_load_req(req), .o_grant_id(gid), .o_busy(busy),
    .o_drop(drop), .o_timeout(tmo), .o_sent_count(sent)
  );

  always #5 clk = ~clk;

  // Serializer model: start bit, LSB-first data, optional parity, stop bit;
  // load_req toggles on the stop-bit edge.
  logic        freeze = 1'b0;
  logic        m_act;
  logic [15:0] m_data;
  logic [3:0]  m_w;
  logic [1:0]  m_p;
  int          m_idx;
  logic [17:0] cap_bits;
  int          cap_len;

  function automatic logic par_of(input logic [15:0] d, input logic [3:0] w);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 16; i++) if (i < int'(w)) p ^= d[i];
    return p;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      req   <= 1'b1;
      m_act <= 1'b0;
    end else if (!freeze) begin
      if (!m_act) begin
        if (ack == req) begin
          m_act <= 1'b1; m_data <= tx_data; m_w <= tx_w; m_p <= tx_p;
          m_idx <= 0; cap_bits <= '0; cap_len <= 1;
        end
      end else if (m_idx < int'(m_w)) begin
        cap_bits[cap_len] <= m_data[m_idx];
        cap_len <= cap_len + 1; m_idx <= m_idx + 1;
      end else if (m_p[1] && m_idx == int'(m_w)) begin
        cap_bits[cap_len] <= par_of(m_data, m_w) ^ m_p[0];
        cap_len <= cap_len + 1; m_idx <= m_idx + 1;
      end else begin
        cap_bits[cap_len] <= 1'b1;
        cap_len <= cap_len + 1;
        req   <= ~req;
        m_act <= 1'b0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_ready(output bit ok, output int cyc);
    ok = 1'b0; cyc = 0;
    #1;
    while (!ok && cyc < 200) begin
      if (|ready) ok = 1'b1;
      else begin @(negedge clk); #1; cyc++; end
    end
    chk("ready_seen", 32'(ok), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 200) begin n++; @(posedge clk); #1; end
    if (n >= 200) chk("busy_bounded", 32'(busy), 32'd0);
  endtask

  typedef struct {
    int          rq;
    logic [15:0] d;
    logic [3:0]  w;
    logic [1:0]  p;
    logic        drop;
    int          busy_cyc;
    int          len;
    logic [17:0] bits;
  } vec_t;

  vec_t tbl[5];

  initial begin
    bit   ok;
    int   cyc, n, to_at, exp_sent;
    logic [3:0] last_w;
    logic seen;

    // {req, data, width, parity, drop, busy cycles, line length, line bits}
    tbl[0] = '{2, 16'h00A5, 4'd8,  2'b10, 1'b0, 12, 11, 18'h0054A};
    tbl[1] = '{3, 16'h7FFF, 4'd15, 2'b00, 1'b0, 18, 17, 18'h1FFFE};
    tbl[2] = '{1, 16'h0006, 4'd3,  2'b11, 1'b0, 7,  6,  18'h0003C};
    tbl[3] = '{0, 16'h0003, 4'd2,  2'b11, 1'b0, 6,  5,  18'h0001E};
    tbl[4] = '{1, 16'h1234, 4'd0,  2'b10, 1'b1, 0,  0,  18'h00000};
    exp_sent = 0;
    last_w   = 4'd0;

    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(tx_data), 0);
    chk("rst_gid", 32'(gid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_sent", 32'(sent), 0);
    chk("rst_ready", 32'(ready), 0);

    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      valid = '0;
      valid[tbl[v].rq] = 1'b1;
      data[16*tbl[v].rq +: 16] = tbl[v].d;
      width[4*tbl[v].rq +: 4]  = tbl[v].w;
      par[2*tbl[v].rq +: 2]    = tbl[v].p;
      wait_ready(ok, cyc);
      chk("tbl_ready", 32'(ready), 32'(1 << tbl[v].rq));
      chk("tbl_drop", 32'(drop), 32'(tbl[v].drop));
      @(posedge clk); #1;
      valid = '0;
      chk("tbl_gid", 32'(gid), 32'(tbl[v].rq));
      if (!tbl[v].drop) begin
        chk("tbl_txdata", 32'(tx_data), 32'(tbl[v].d));
        wait_done(n);
        chk("tbl_busy_cycles", 32'(n), 32'(tbl[v].busy_cyc));
        exp_sent++;
        chk("tbl_sent", 32'(sent), 32'(exp_sent));
        chk("tbl_line_len", 32'(cap_len), 32'(tbl[v].len));
        chk("tbl_line_bits", 32'(cap_bits), 32'(tbl[v].bits));
        last_w = tbl[v].w;
      end else begin
        chk("drop_busy", 32'(busy), 0);
        chk("drop_width_kept", 32'(tx_w), 32'(last_w));
        chk("drop_ser_idle", 32'(ack ^ req), 1);
      end
    end

    // Pointer after the drop on requester 1 must sit at 2: {0,1} valid -> 0.
    @(negedge clk);
    valid = 4'b0011; width[7:0] = 8'h44; par[3:0] = 4'b0000;
    wait_ready(ok, cyc);
    chk("ptr_after_drop", 32'(ready), 32'b0001);
    @(posedge clk); #1;
    valid = '0;
    wait_done(n);
    exp_sent++;
    chk("ptr_sent", 32'(sent), 32'(exp_sent));

    // Gap 5 spacing, then enable low mid-frame.
    @(negedge clk);
    gap = 4'd5; valid = 4'b1000; width[15:12] = 4'd4; par[7:6] = 2'b00; data[63:48] = 16'h5A5A;
    wait_ready(ok, cyc);
    chk("gap_ready1", 32'(ready), 32'b1000);
    @(posedge clk); #1;
    wait_ready(ok, cyc);
    chk("gap_spacing", 32'(cyc), 32'd13);
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    en = 1'b0;
    wait_done(n);
    exp_sent += 2;
    chk("en_low_frame_done", 32'(sent), 32'(exp_sent));
    seen = 1'b0;
    repeat (20) begin @(negedge clk); #1; if (|ready) seen = 1'b1; end
    chk("no_grant_disabled", 32'(seen), 0);
    @(negedge clk); en = 1'b1; #1;
    chk("grant_on_enable", 32'(ready), 32'b1000);
    @(posedge clk); #1;
    valid = '0;
    wait_done(n);
    exp_sent++;
    chk("en_sent", 32'(sent), 32'(exp_sent));
    gap = 4'd0;

    // Watchdog with a frozen serializer.
    @(negedge clk);
    freeze = 1'b1; valid = 4'b0010; width[7:4] = 4'd5;
    wait_ready(ok, cyc);
    chk("wd_ready", 32'(ready), 32'b0010);
    @(posedge clk); #1;
    valid = '0;
    to_at = 0; n = 0;
    while (to_at == 0 && n < 80) begin
      @(negedge clk); n++;
      if (tmo) to_at = n;
    end
    chk("wd_timeout_cycle", 32'(to_at), 32'd40);
    @(posedge clk); #1;
    chk("wd_ack_forced", 32'(ack ^ req), 1);
    chk("wd_sent_unchanged", 32'(sent), 32'(exp_sent));
    chk("wd_busy_clear", 32'(busy), 0);
    chk("wd_pulse_ends", 32'(tmo), 0);
    @(negedge clk); freeze = 1'b0;

    // Reset three cycles into a frame.
    @(negedge clk);
    valid = 4'b0100; width[11:8] = 4'd8; par[5:4] = 2'b10; data[47:32] = 16'h00A5;
    wait_ready(ok, cyc);
    @(posedge clk); #1;
    valid = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_ack", 32'(ack), 0);
    chk("mid_rst_data", 32'(tx_data), 0);
    chk("mid_rst_width", 32'(tx_w), 0);
    chk("mid_rst_par", 32'(tx_p), 0);
    chk("mid_rst_gid", 32'(gid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_sent", 32'(sent), 0);
    chk("mid_rst_pulses", 32'({drop, tmo, ready}), 0);
    exp_sent = 0;
    @(negedge clk); rst = 1'b0;

    // Contention: all valid, width 4, gap 0 -> 0,1,2,3,0 every 8 cycles.
    valid = 4'b1111; width = {4{4'd4}}; par = '0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(ok, cyc);
      chk("rr_order", 32'(ready), 32'(1 << (g % 4)));
      if (g > 0) chk("rr_spacing", 32'(cyc), 32'd8);
      @(posedge clk); #1;
    end
    valid = '0;
    wait_done(n);
    exp_sent += 5;
    chk("rr_sent", 32'(sent), 32'(exp_sent));

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
